present80_dec: RTL and testbench

//  Iterative PRESENT-80 block decryptor; companion to the encrypt datapath (forward S-box / pLayer).

---
 rtl/present_pkg.sv | 50 +++++
 rtl/inv_sbox.sv | 18 +
 rtl/sbox.sv | 19 +
 rtl/present80_dec.sv | 147 ++++++++++++++
 tb/tb_present80_dec.sv | 138 +++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared types and pure datapath helpers for the PRESENT-80 decryptor:
// FSM encoding, widths, inverse bit permutation and key-schedule steps.
package present_pkg;

  localparam int KEY_W      = 80;
  localparam int BLK_W      = 64;
  localparam int ROUNDS_DEF = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_WHITEN,
    ST_DEC,
    ST_DONE
  } fsm_t;

  // Inverse pLayer: forward moves bit i to (16*i) mod 63, so gather from there.
  function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] din);
    logic [BLK_W-1:0] dout;
    dout = '0;
    for (int i = 0; i < 63; i++) begin
      dout[i] = din[(16 * i) % 63];
    end
    dout[63] = din[63];
    return dout;
  endfunction

  // Forward step; s_top is S(k[18:15]), the nibble that lands on top after k<<<61.
  function automatic logic [KEY_W-1:0] key_fwd_step(input logic [KEY_W-1:0] k,
                                                    input logic [3:0]       s_top,
                                                    input logic [4:0]       rnd);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = s_top;
    r[19:15]   = r[19:15] ^ rnd;
    return r;
  endfunction

  // Inverse step; si_top is S^-1(k[79:76]). Undoes key_fwd_step for the same rnd.
  function automatic logic [KEY_W-1:0] key_inv_step(input logic [KEY_W-1:0] k,
                                                    input logic [3:0]       si_top,
                                                    input logic [4:0]       rnd);
    logic [KEY_W-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rnd;
    t[79:76]   = si_top;
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// PRESENT inverse 4-bit S-box, purely combinational.
module inv_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'h5;  4'h1: dout = 4'hE;  4'h2: dout = 4'hF;  4'h3: dout = 4'h8;
      4'h4: dout = 4'hC;  4'h5: dout = 4'h1;  4'h6: dout = 4'h2;  4'h7: dout = 4'hD;
      4'h8: dout = 4'hB;  4'h9: dout = 4'h4;  4'hA: dout = 4'h6;  4'hB: dout = 4'h3;
      4'hC: dout = 4'h0;  4'hD: dout = 4'h7;  4'hE: dout = 4'h9;  4'hF: dout = 4'hA;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/sbox.sv
// PRESENT forward 4-bit S-box, purely combinational.
module sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // NOTE: default assignment before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;  4'h1: dout = 4'h5;  4'h2: dout = 4'h6;  4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;  4'h5: dout = 4'h0;  4'h6: dout = 4'hA;  4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;  4'h9: dout = 4'hE;  4'hA: dout = 4'hF;  4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;  4'hD: dout = 4'h7;  4'hE: dout = 4'h1;  4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryptor, one inverse round per clock.
// Optional K32 cache enabled by defining PRESENT_DEC_KEYCACHE_EN.
module present80_dec
  import present_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [BLK_W-1:0] ct_in,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] pt_out
);

  localparam logic [4:0] RND_LAST = 5'(ROUNDS);

  fsm_t             fsm;
  logic [BLK_W-1:0] state;
  logic [KEY_W-1:0] key;
  logic [4:0]       rnd;

  logic [BLK_W-1:0] state_pinv;
  logic [BLK_W-1:0] state_sinv;
  logic [3:0]       key_s_fwd;
  logic [3:0]       key_s_inv;
  logic [KEY_W-1:0] key_next;
  logic [KEY_W-1:0] key_prev;

`ifdef PRESENT_DEC_KEYCACHE_EN
  logic [KEY_W-1:0] cache_key;
  logic [KEY_W-1:0] cache_k32;
  logic             cache_valid;
`endif

  assign state_pinv = inv_player(state);

  for (genvar g = 0; g < 16; g++) begin : g_sinv
    inv_sbox u_inv_sbox (
      .din  (state_pinv[4*g +: 4]),
      .dout (state_sinv[4*g +: 4])
    );
  end

  inv_sbox u_key_inv_sbox (
    .din  (key[79:76]),
    .dout (key_s_inv)
  );

  sbox u_key_sbox (
    .din  (key[18:15]),
    .dout (key_s_fwd)
  );

  assign key_next = key_fwd_step(key, key_s_fwd, rnd);
  assign key_prev = key_inv_step(key, key_s_inv, rnd);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      pt_out <= '0;
      state  <= '0;
      key    <= '0;
      rnd    <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
      // NOTE: cache storage is reset explicitly; a stale valid bit would hand out a wrong K32.
      cache_key   <= '0;
      cache_k32   <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef PRESENT_DEC_KEYCACHE_EN
            if (cache_valid && (key_in == cache_key)) begin
              // Hit: whitening is folded into the accept edge, rounds start next edge.
              key   <= cache_k32;
              state <= ct_in ^ cache_k32[79:16];
              rnd   <= RND_LAST;
              fsm   <= ST_DEC;
            end else begin
              key         <= key_in;
              state       <= ct_in;
              rnd         <= 5'd1;
              fsm         <= ST_KEYEXP;
              cache_key   <= key_in;
              cache_valid <= 1'b0;
            end
`else
            key   <= key_in;
            state <= ct_in;
            rnd   <= 5'd1;
            fsm   <= ST_KEYEXP;
`endif
          end
        end

        ST_KEYEXP: begin
          key <= key_next;
          if (rnd == RND_LAST) begin
            fsm <= ST_WHITEN;
`ifdef PRESENT_DEC_KEYCACHE_EN
            cache_k32   <= key_next;
            cache_valid <= 1'b1;
`endif
          end else begin
            rnd <= rnd + 5'd1;
          end
        end

        ST_WHITEN: begin
          state <= state ^ key[79:16];
          rnd   <= RND_LAST;
          fsm   <= ST_DEC;
        end

        ST_DEC: begin
          key   <= key_prev;
          state <= state_sinv ^ key_prev[79:16];
          if (rnd == 5'd1) begin
            fsm <= ST_DONE;
          end else begin
            rnd <= rnd - 5'd1;
          end
        end

        ST_DONE: begin
          done   <= 1'b1;
          pt_out <= state;
          busy   <= 1'b0;
          fsm    <= ST_IDLE;
        end

        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present80_dec.sv
// Directed self-checking bench for present80_dec using published PRESENT-80 vectors.
module tb_present80_dec;

`ifdef PRESENT_DEC_KEYCACHE_EN
  localparam int HIT_LAT = 32;
`else
  localparam int HIT_LAT = 64;
`endif
  localparam int FULL_LAT = 64;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] P1 = {64{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [79:0] key_in = '0;
  logic [63:0] ct_in = '0;
  logic        busy;
  logic        done;
  logic [63:0] pt_out;

  int n_cmp = 0;
  int n_bad = 0;

  present80_dec dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .key_in (key_in),
    .ct_in  (ct_in),
    .busy   (busy),
    .done   (done),
    .pt_out (pt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One request; extra start pulses injected at edges pa/pb (0 = none) must be ignored.
  task automatic run(input string tag, input logic [79:0] k, input logic [63:0] ct,
                     input logic [63:0] exp_pt, input int exp_lat, input int pa, input int pb);
    int          lat;
    int          ndone;
    logic [63:0] pt_at_done;
    lat        = 0;
    ndone      = 0;
    pt_at_done = '0;
    @(negedge clk);
    key_in = k;
    ct_in  = ct;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = ~k;
    ct_in  = ~ct;
    check({tag, ".busy_on"}, 64'(busy), 64'd1);
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat        = n;
          pt_at_done = pt_out;
        end
      end
      start = (n == pa) || (n == pb);
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".ndone"}, 64'(ndone), 64'd1);
    check({tag, ".pt"}, pt_at_done, exp_pt);
    check({tag, ".pt_hold"}, pt_out, exp_pt);
    check({tag, ".busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.pt", pt_out, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("t1", K0, 64'h5579C1387B228445, P0, FULL_LAT, 0, 0);
    run("t2", K1, 64'hE72C46C0F5945049, P0, FULL_LAT, 0, 0);
    run("t3a", K0, 64'hA112FFC72F68417B, P1, FULL_LAT, 0, 0);
    run("t3b", K1, 64'h3333DCD3213210D2, P1, FULL_LAT, 63, 0);
    run("t4", K0, 64'hA112FFC72F68417B, P1, FULL_LAT, 10, 40);

    // Abort mid-run: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    key_in = K1;
    ct_in  = 64'hE72C46C0F5945049;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n < 30; n++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.busy", 64'(busy), 64'd0);
    check("t5.done", 64'(done), 64'd0);
    check("t5.pt", pt_out, 64'd0);
    @(posedge clk);
    #1;
    check("t5.hold_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (done) check("t5.no_done", 64'(done), 64'd0);
    end

    run("t5.fresh", K0, 64'h5579C1387B228445, P0, FULL_LAT, 0, 0);
    run("t6.again", K0, 64'h5579C1387B228445, P0, HIT_LAT, 0, 0);
    run("t6.newkey", K1, 64'hE72C46C0F5945049, P0, FULL_LAT, 0, 0);
    run("t6.hit2", K1, 64'h3333DCD3213210D2, P1, HIT_LAT, 31, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
